// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//
// UART transmit serializer that sits downstream of the string-transmission
// controller. It accepts one byte per start/listo handshake and sends it as
// a start bit, 8 data bits (LSB first), an optional parity bit and one stop
// bit, each lasting BAUD_DIV clk cycles.
//
// Parameters:
//   BAUD_DIV  clk cycles per bit (2..65535), default 868 = 100 MHz / 115200
//   PARITY    0 = none, 1 = even, 2 = odd
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high
//   start  in   transmit request, only looked at while idle, may be held high
//   data   in   byte to send, captured on the accepting edge only
//   tx     out  registered serial line, idle-high
//   listo  out  registered, high = idle and able to accept a byte
module uart_tx_serializer #(
  parameter int BAUD_DIV = 868,
  parameter int PARITY   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       listo
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam bit          PAR_EN    = (PARITY != 0);
  localparam bit          PAR_ODD   = (PARITY == 2);

  logic [2:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        par_bit;
  logic        bit_done;

  // Last cycle of the current bit period; the counter wraps on this edge.
  assign bit_done = (baud_cnt == BAUD_LAST);

  // Framing state machine. tx is registered and always loaded with the
  // value of the *next* bit on a boundary edge, so the line changes exactly
  // on bit boundaries and falls on the very edge that accepts start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      baud_cnt  <= 16'd0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
      par_bit   <= 1'b0;
      tx        <= 1'b1;
      listo     <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          tx       <= 1'b1;
          listo    <= 1'b1;
          baud_cnt <= 16'd0;
          bit_cnt  <= 3'd0;
          if (start) begin
            shift_reg <= data;
            // Parity is fixed at accept time so later data changes cannot leak in.
            par_bit   <= (^data) ^ PAR_ODD;
            state     <= S_START;
            tx        <= 1'b0;
            listo     <= 1'b0;
          end
        end

        S_START: begin
          if (bit_done) begin
            baud_cnt <= 16'd0;
            state    <= S_DATA;
            tx       <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (bit_done) begin
            baud_cnt <= 16'd0;
            if (bit_cnt == 3'd7) begin
              if (PAR_EN) begin
                state <= S_PAR;
                tx    <= par_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              // shift_reg[1] becomes shift_reg[0] on this same edge.
              tx        <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        S_PAR: begin
          if (bit_done) begin
            baud_cnt <= 16'd0;
            state    <= S_STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        S_STOP: begin
          if (bit_done) begin
            baud_cnt <= 16'd0;
            state    <= S_IDLE;
            tx       <= 1'b1;
            listo    <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        default: begin
          // Unused encodings recover to a clean idle line.
          state    <= S_IDLE;
          baud_cnt <= 16'd0;
          bit_cnt  <= 3'd0;
          tx       <= 1'b1;
          listo    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer
//
// Self-checking bench for uart_tx_serializer. Three instances share clk,
// reset and data, all with BAUD_DIV=4: p0 without parity, p1 even parity,
// p2 odd parity. A table of hand-computed frames is sent through the
// selected instance, followed by sequences for reset, held start and
// reset in the middle of a frame.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       start_p0, start_p1, start_p2;
  logic       tx_p0, tx_p1, tx_p2;
  logic       listo_p0, listo_p1, listo_p2;
  int         sel;
  logic       tx_sel, listo_sel;

  int total = 0;
  int bad   = 0;

  uart_tx_serializer #(.BAUD_DIV(4), .PARITY(0)) dut_p0 (
    .clk(clk), .reset(reset), .start(start_p0), .data(data), .tx(tx_p0), .listo(listo_p0)
  );
  uart_tx_serializer #(.BAUD_DIV(4), .PARITY(1)) dut_p1 (
    .clk(clk), .reset(reset), .start(start_p1), .data(data), .tx(tx_p1), .listo(listo_p1)
  );
  uart_tx_serializer #(.BAUD_DIV(4), .PARITY(2)) dut_p2 (
    .clk(clk), .reset(reset), .start(start_p2), .data(data), .tx(tx_p2), .listo(listo_p2)
  );

  always #5 clk = ~clk;

  // Route the outputs of the instance under test to one pair of signals.
  always_comb begin
    tx_sel    = tx_p0;
    listo_sel = listo_p0;
    case (sel)
      1: begin tx_sel = tx_p1; listo_sel = listo_p1; end
      2: begin tx_sel = tx_p2; listo_sel = listo_p2; end
      default: ;
    endcase
  end

  typedef struct {
    int          which;
    logic [7:0]  d;
    logic [10:0] exp_frame;  // bit 0 = first bit on the line (start bit)
    int          nbits;
    int          exp_low;
    int          pulse_at;   // frame cycle of an extra start pulse, -1 = none
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic applyStimulus(input int which, input logic value);
    case (which)
      0: start_p0 = value;
      1: start_p1 = value;
      default: start_p2 = value;
    endcase
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Send one byte and compare tx every cycle against the expected frame.
  // Cycle c=0 is the falling edge right after the accepting edge.
  task automatic run_frame(input int which, input logic [7:0] d, input logic [10:0] exp_frame,
                           input int nbits, input int pulse_at,
                           output int low_cnt, output int bad_cycles, output int timed_out);
    sel  = which;
    data = d;
    @(negedge clk);
    applyStimulus(which, 1'b1);
    low_cnt    = 0;
    bad_cycles = 0;
    timed_out  = 1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) applyStimulus(which, 1'b0);
      if (c == 5) data = ~d;
      if (pulse_at >= 0 && c == pulse_at) applyStimulus(which, 1'b1);
      if (pulse_at >= 0 && c == pulse_at + 1) applyStimulus(which, 1'b0);
      if (c < nbits * 4) begin
        if (tx_sel !== exp_frame[c / 4]) bad_cycles++;
      end else if (tx_sel !== 1'b1) begin
        bad_cycles++;
      end
      if (listo_sel === 1'b1) begin
        timed_out = 0;
        break;
      end
      low_cnt++;
    end
  endtask

  int         low_cnt, bad_cycles, timed_out, idle_bad;
  int         acc[3];
  logic [7:0] rx[3];
  int         k, fc, done;
  logic       prev_listo;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{0, 8'hA5, 11'b0_1_10100101_0, 10, 40, -1};
    vecs[1] = '{1, 8'h07, 11'b1_1_00000111_0, 11, 44, -1};
    vecs[2] = '{2, 8'h07, 11'b1_0_00000111_0, 11, 44, -1};
    vecs[3] = '{0, 8'h00, 11'b0_1_00000000_0, 10, 40, -1};
    vecs[4] = '{0, 8'hFF, 11'b0_1_11111111_0, 10, 40, -1};
    vecs[5] = '{1, 8'h00, 11'b1_0_00000000_0, 11, 44, -1};
    vecs[6] = '{2, 8'h00, 11'b1_1_00000000_0, 11, 44, -1};
    vecs[7] = '{1, 8'h3C, 11'b1_0_00111100_0, 11, 44, -1};
    vecs[8] = '{2, 8'h80, 11'b1_0_10000000_0, 11, 44, -1};
    vecs[9] = '{0, 8'h3C, 11'b0_1_00111100_0, 10, 40, 10};

    // Reset held with start high: line stays idle, then a frame begins.
    sel      = 0;
    reset    = 1'b1;
    data     = 8'h55;
    start_p0 = 1'b1;
    start_p1 = 1'b0;
    start_p2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("reset_tx_%0d", i), int'(tx_sel), 1);
      checkOutput($sformatf("reset_listo_%0d", i), int'(listo_sel), 1);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("release_tx", int'(tx_sel), 1);
    checkOutput("release_listo", int'(listo_sel), 1);
    @(negedge clk);
    checkOutput("first_accept_tx", int'(tx_sel), 0);
    checkOutput("first_accept_listo", int'(listo_sel), 0);
    applyStimulus(0, 1'b0);
    timed_out = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (listo_sel === 1'b1) begin
        timed_out = 0;
        break;
      end
    end
    checkOutput("first_frame_timeout", timed_out, 0);

    // Table of single frames, each followed by an idle check.
    for (int i = 0; i < NV; i++) begin
      run_frame(vecs[i].which, vecs[i].d, vecs[i].exp_frame, vecs[i].nbits,
                vecs[i].pulse_at, low_cnt, bad_cycles, timed_out);
      checkOutput($sformatf("v%0d_timeout", i), timed_out, 0);
      checkOutput($sformatf("v%0d_tx_bad_cycles", i), bad_cycles, 0);
      checkOutput($sformatf("v%0d_listo_low", i), low_cnt, vecs[i].exp_low);
      idle_bad = 0;
      repeat (6) begin
        @(negedge clk);
        if (listo_sel !== 1'b1 || tx_sel !== 1'b1) idle_bad++;
      end
      checkOutput($sformatf("v%0d_idle_after", i), idle_bad, 0);
    end

    // Held start across three frames, data changed mid-frame.
    sel  = 0;
    data = 8'h41;
    @(negedge clk);
    applyStimulus(0, 1'b1);
    prev_listo = 1'b1;
    k    = 0;
    done = 0;
    acc  = '{0, 0, 0};
    rx   = '{8'h00, 8'h00, 8'h00};
    for (int c = 0; c < 400 && done == 0; c++) begin
      @(negedge clk);
      if (listo_sel === 1'b0 && prev_listo === 1'b1) begin
        if (k < 3) acc[k] = c;
        k++;
      end
      prev_listo = listo_sel;
      if (k >= 1 && k <= 3) begin
        fc = c - acc[k - 1];
        if (fc == 0) begin
          data = 8'hE7;
          if (k == 3) applyStimulus(0, 1'b0);
        end
        if (fc == 20) data = (k == 1) ? 8'h42 : 8'h43;
        if (fc % 4 == 1 && fc / 4 >= 1 && fc / 4 <= 8) rx[k - 1][fc / 4 - 1] = tx_sel;
        if (k == 3 && fc > 0 && listo_sel === 1'b1) done = 1;
      end
    end
    applyStimulus(0, 1'b0);
    checkOutput("held_done", done, 1);
    checkOutput("held_accepts", k, 3);
    checkOutput("held_gap_1", acc[1] - acc[0], 41);
    checkOutput("held_gap_2", acc[2] - acc[1], 41);
    checkOutput("held_byte_0", int'(rx[0]), 'h41);
    checkOutput("held_byte_1", int'(rx[1]), 'h42);
    checkOutput("held_byte_2", int'(rx[2]), 'h43);

    // Reset during data bit 3 of 8'hC3 (a 0 bit), with start asserted too.
    repeat (3) @(negedge clk);
    sel  = 0;
    data = 8'hC3;
    @(negedge clk);
    applyStimulus(0, 1'b1);
    @(negedge clk);
    applyStimulus(0, 1'b0);
    repeat (17) @(negedge clk);
    checkOutput("mid_pre_tx", int'(tx_sel), 0);
    checkOutput("mid_pre_listo", int'(listo_sel), 0);
    reset = 1'b1;
    applyStimulus(0, 1'b1);
    @(negedge clk);
    checkOutput("mid_reset_tx", int'(tx_sel), 1);
    checkOutput("mid_reset_listo", int'(listo_sel), 1);
    applyStimulus(0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_after_tx", int'(tx_sel), 1);
    checkOutput("mid_after_listo", int'(listo_sel), 1);
    run_frame(0, 8'h96, 11'b0_1_10010110_0, 10, -1, low_cnt, bad_cycles, timed_out);
    checkOutput("mid_next_timeout", timed_out, 0);
    checkOutput("mid_next_tx_bad_cycles", bad_cycles, 0);
    checkOutput("mid_next_listo_low", low_cnt, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
